// File: rtl/float_mul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : float_mul_result_buffer
// Purpose  : Credit-based FIFO stage behind a fixed-latency float multiplier.
// Option   : FLOAT_MUL_CLASSIFY_EN stores zero/infinity flags per entry.
// Revision : 1.0 - initial release
// ============================================================================
module float_mul_result_buffer #(
   parameter int  MANTISSA_SIZE = 23,
   parameter int  EXPONENT_SIZE = 8,
   parameter int  LATENCY       = 4,
   parameter int  DEPTH         = 8,
   localparam int FLOAT_SIZE    = 1 + EXPONENT_SIZE + MANTISSA_SIZE,
   localparam int CNT_W         = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FLOAT_SIZE-1:0] prod,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FLOAT_SIZE-1:0] out_data,
   output logic [1:0]            out_flags,
   output logic [CNT_W-1:0]      count
);

   localparam int               c_PTR_W     = $clog2(DEPTH);
   localparam logic [CNT_W:0]   c_DEPTH_EXT = (CNT_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

   logic [LATENCY-1:0]    r_vpipe;
   logic [CNT_W-1:0]      r_inflight;
   logic [CNT_W-1:0]      r_count;
   logic [c_PTR_W-1:0]    r_wrPtr;
   logic [c_PTR_W-1:0]    r_rdPtr;
   logic [FLOAT_SIZE-1:0] r_mem [DEPTH];

   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic [CNT_W:0]        w_credits;

   // Credit is taken from registered state only, so a pop frees a slot one cycle later.
   assign w_credits = {1'b0, r_count} + {1'b0, r_inflight};
   assign in_ready  = (w_credits < c_DEPTH_EXT);
   assign w_issue   = in_valid & in_ready;
   assign w_push    = r_vpipe[LATENCY-1];
   assign out_valid = (r_count != '0);
   assign w_pop     = out_valid & out_ready;
   assign out_data  = r_mem[r_rdPtr];
   assign count     = r_count;

   generate
      if (LATENCY == 1) begin : g_vpipeSingle
         always_ff @(posedge clk) begin
            if (reset) r_vpipe <= '0;
            else       r_vpipe <= w_issue;
         end
      end else begin : g_vpipeShift
         always_ff @(posedge clk) begin
            if (reset) r_vpipe <= '0;
            else       r_vpipe <= {r_vpipe[LATENCY-2:0], w_issue};
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_inflight <= '0;
         r_count    <= '0;
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
      end else begin
         r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_push);
         r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         if (w_push) r_wrPtr <= r_wrPtr + c_PTR_W'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + c_PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= prod;
   end

`ifdef FLOAT_MUL_CLASSIFY_EN
   logic [1:0]               r_flagMem [DEPTH];
   logic [EXPONENT_SIZE-1:0] w_exp;
   logic [MANTISSA_SIZE-1:0] w_mant;
   logic [1:0]               w_prodFlags;

   assign w_exp       = prod[FLOAT_SIZE-2 -: EXPONENT_SIZE];
   assign w_mant      = prod[MANTISSA_SIZE-1:0];
   assign w_prodFlags = {(&w_exp), ((w_exp == '0) && (w_mant == '0))};

   always_ff @(posedge clk) begin
      if (w_push) r_flagMem[r_wrPtr] <= w_prodFlags;
   end

   // Flag storage is not reset, so mask it while the FIFO is empty.
   assign out_flags = out_valid ? r_flagMem[r_rdPtr] : 2'b00;
`else
   assign out_flags = 2'b00;
`endif

   // Credit accounting must make a push into a full FIFO impossible.
   a_noOverflow : assert property (@(posedge clk) disable iff (reset)
      !(w_push && (r_count == c_DEPTH_CNT)));

endmodule
`default_nettype wire

// File: tb/tb_float_mul_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_mul_result_buffer
// Purpose  : Directed self-checking bench; models the multiplier as a delay line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_mul_result_buffer;

   localparam int LAT = 4;
   localparam int DEP = 8;

`ifdef FLOAT_MUL_CLASSIFY_EN
   localparam logic [1:0] FL_INF  = 2'b10;
   localparam logic [1:0] FL_ZERO = 2'b01;
`else
   localparam logic [1:0] FL_INF  = 2'b00;
   localparam logic [1:0] FL_ZERO = 2'b00;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] prod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_flags;
   logic [3:0]  count;
   logic [31:0] opProd;
   logic [31:0] mpipe [LAT];

   int checks   = 0;
   int failures = 0;
   int rx       = 0;

   float_mul_result_buffer #(
      .MANTISSA_SIZE(23),
      .EXPONENT_SIZE(8),
      .LATENCY(LAT),
      .DEPTH(DEP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .prod(prod),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_flags(out_flags),
      .count(count)
   );

   always #5 clk = ~clk;

   // Multiplier stand-in: the precomputed product emerges LAT clocks after issue.
   always @(posedge clk) begin
      mpipe[0] <= (in_valid && in_ready) ? opProd : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign prod = mpipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sampleStream();
      if (out_valid) begin
         chk("t4_order", out_data, 32'h5000_0000 + 32'(rx));
         rx++;
      end else if (rx > 0 && rx < 100) begin
         chk("t4_gap", {31'd0, out_valid}, 32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opProd    = 32'd0;
      repeat (3) tick();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count",     {28'd0, count},     32'd0);
      chk("rst_flags",     {30'd0, out_flags}, 32'd0);
      reset = 1'b0;
      tick();

      // Single product: 2.0 * 3.0 = 6.0, valid LAT+1 clocks after issue
      out_ready = 1'b1;
      in_valid  = 1'b1;
      opProd    = 32'h40C0_0000;
      tick();
      in_valid = 1'b0;
      chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) tick();
      chk("t2_early", {31'd0, out_valid}, 32'd0);
      tick();
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_data",  out_data,           32'h40C0_0000);
      chk("t2_flags", {30'd0, out_flags}, 32'd0);
      chk("t2_count", {28'd0, count},     32'd1);
      tick();
      chk("t2_drain_count", {28'd0, count},     32'd0);
      chk("t2_drain_valid", {31'd0, out_valid}, 32'd0);

      // Fill: 8 back-to-back issues with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         opProd   = 32'h4100_0000 + 32'(i);
         chk("t3_credit", {31'd0, in_ready}, 32'd1);
         tick();
      end
      in_valid = 1'b0;
      chk("t3_no_credit", {31'd0, in_ready}, 32'd0);
      chk("t3_count_e8",  {28'd0, count},    32'd4);
      repeat (3) tick();
      chk("t3_count_e11", {28'd0, count},    32'd7);
      tick();
      chk("t3_count_full", {28'd0, count},    32'd8);
      chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("t3_pop_pending_ready", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         chk("t3_head", out_data, 32'h4100_0000 + 32'(i));
         tick();
         chk("t3_count_drain", {28'd0, count}, 32'(7 - i));
         if (i == 0) chk("t3_credit_back", {31'd0, in_ready}, 32'd1);
      end
      chk("t3_empty", {31'd0, out_valid}, 32'd0);

      // Streaming: 100 ops with the consumer always ready
      rx = 0;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         opProd   = 32'h5000_0000 + 32'(i);
         chk("t4_ready", {31'd0, in_ready}, 32'd1);
         tick();
         sampleStream();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 20 && rx < 100; k++) begin
         tick();
         sampleStream();
      end
      chk("t4_total", 32'(rx), 32'd100);

      // Reset while three products are still inside the multiplier
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         opProd   = 32'h6000_0000 + 32'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_ready", {31'd0, in_ready}, 32'd1);
      chk("t5_count", {28'd0, count},    32'd0);
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("t5_no_stale", {27'd0, count, out_valid}, 32'd0);
      end

      // Classification: overflow to infinity, then exact zero
      out_ready = 1'b0;
      in_valid  = 1'b1;
      opProd    = 32'h7F80_0000;
      tick();
      opProd = 32'h0000_0000;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && count != 4'd2; k++) tick();
      chk("t6_count",     {28'd0, count},     32'd2);
      chk("t6_inf_data",  out_data,           32'h7F80_0000);
      chk("t6_inf_flags", {30'd0, out_flags}, {30'd0, FL_INF});
      out_ready = 1'b1;
      tick();
      chk("t6_zero_data",  out_data,           32'h0000_0000);
      chk("t6_zero_flags", {30'd0, out_flags}, {30'd0, FL_ZERO});
      tick();
      chk("t6_empty", {31'd0, out_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
